// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the mux_nx1_stream block.
//   - mux_mode_t : channel-selection mode type
//   - MODE_SEL   : explicit select, the channel index comes from the sel port
//   - MODE_RR    : round-robin among the valid channels
// ----------------------------------------------------------------------------
package mux_pkg;

    typedef logic mux_mode_t;

    localparam mux_mode_t MODE_SEL = 1'b0;
    localparam mux_mode_t MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. It grants the first requester found
//   when scanning ptr, ptr+1, ... and wrapping from N_CH-1 to 0.
// Ports
//   req      in   N_CH    request vector
//   ptr      in   SEL_W   highest-priority index (must be < N_CH)
//   gnt      out  N_CH    one-hot grant, all zero when there is no request
//   gnt_idx  out  SEL_W   index of the granted requester (0 when none)
//   any      out  1       at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    // The request vector is duplicated so that a wrapping scan becomes a plain
    // scan over the window [ptr, ptr+N_CH) of the double-width vector.
    logic [2*N_CH-1:0] w_req_dbl;

    assign w_req_dbl = {req, req};

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        // The scan runs downwards, so the lowest index in the window is the
        // one left in gnt_idx when the loop ends.
        for (int j = 2 * N_CH - 1; j >= 0; j--) begin
            if (w_req_dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + int'(N_CH))) begin
                any     = 1'b1;
                gnt_idx = (j >= int'(N_CH)) ? SEL_W'(j - int'(N_CH)) : SEL_W'(j);
            end
        end
        gnt = any ? (N_CH'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// ----------------------------------------------------------------------------
// mux_nx1_stream
//   N_CH-channel, WIDTH-bit stream multiplexer with a one-deep registered
//   output slot. The channel is chosen either explicitly through sel or by
//   round-robin among the valid channels.
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_data    in   N_CH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   in   N_CH         per-channel valid
//   in_ready   out  N_CH         per-channel accept, at most one bit set
//   mode       in   1            MODE_SEL (explicit sel) or MODE_RR (round-robin)
//   sel        in   SEL_W        channel index used in MODE_SEL
//   out_data   out  WIDTH        registered data of the pending beat
//   out_valid  out  1            the output slot holds a beat
//   out_ready  in   1            downstream accepts the beat this cycle
//   out_ch     out  SEL_W        channel that supplied out_data
// ----------------------------------------------------------------------------
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [SEL_W-1:0] r_out_ch;
    logic [SEL_W-1:0] w_out_ch_nxt;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_rr_ptr_nxt;

    logic             w_load_en;
    logic [N_CH-1:0]  w_sel_onehot;
    logic             w_sel_valid;
    logic [N_CH-1:0]  w_rr_gnt;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_any;
    logic             w_is_rr;
    logic [N_CH-1:0]  w_cand_onehot;
    logic [SEL_W-1:0] w_cand_idx;
    logic             w_cand_valid;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_xfer;

    // The slot can take a new beat when it is empty or is being drained now.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_is_rr   = (mode == MODE_RR);

    // Explicit-select decode. A sel value with no matching channel (only
    // possible when N_CH is not a power of two) never produces a candidate.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_valid  = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_valid     = in_valid[i];
            end
        end
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx),
        .any     (w_rr_any)
    );

    assign w_cand_onehot = w_is_rr ? w_rr_gnt : w_sel_onehot;
    assign w_cand_idx    = w_is_rr ? w_rr_idx : sel;
    assign w_cand_valid  = w_is_rr ? w_rr_any : w_sel_valid;

    // No grant is ever offered while reset is asserted.
    assign w_xfer   = rst_n && w_load_en && w_cand_valid;
    assign in_ready = w_xfer ? w_cand_onehot : '0;

    always_comb begin
        w_cand_data = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (w_cand_onehot[i]) begin
                w_cand_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_ch_nxt    = r_out_ch;
        w_rr_ptr_nxt    = r_rr_ptr;
        if (w_load_en) begin
            // Data and channel hold when the slot empties without a refill.
            w_out_valid_nxt = w_xfer;
            if (w_xfer) begin
                w_out_data_nxt = w_cand_data;
                w_out_ch_nxt   = w_cand_idx;
            end
        end
        // Only round-robin grants move the priority pointer.
        if (w_xfer && w_is_rr) begin
            w_rr_ptr_nxt = (w_cand_idx == SEL_W'(N_CH - 1)) ? '0 : w_cand_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_ch    <= w_out_ch_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// ----------------------------------------------------------------------------
// tb_mux_nx1_stream
//   Self-checking bench for mux_nx1_stream: an 8-channel instance for the main
//   scenarios and a 5-channel instance for out-of-range explicit select.
//   Accepted beats are queued as expected output and compared on consumption.
// ----------------------------------------------------------------------------
module tb_mux_nx1_stream;
    import mux_pkg::*;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-channel instance
    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  in_ready8;
    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  out_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [2:0]  out_ch8;

    // 5-channel instance
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic        out_ready5;
    logic [2:0]  out_ch5;

    mux_nx1_stream #(.N_CH(8), .WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .mode      (mode8),
        .sel       (sel8),
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_ch    (out_ch8)
    );

    mux_nx1_stream #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_ch    (out_ch5)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb[$];
    beat_t sb5[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i carries i*16 + salt, so every channel/cycle pair is distinct.
    task automatic set_data(input int salt);
        for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'(i * 16 + salt);
    endtask

    function automatic beat_t mk_beat(input int ch, input int salt);
        beat_t b;
        b.ch   = 3'(ch);
        b.data = 8'(ch * 16 + salt);
        return b;
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        mode8      = MODE_RR;
        sel8       = 3'd0;
        in_valid8  = 8'hFF;
        out_ready8 = 1'b1;
        set_data(0);
        mode5      = MODE_SEL;
        sel5       = 3'd0;
        in_valid5  = 5'h1F;
        in_data5   = '1;
        out_ready5 = 1'b1;
        #3;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({out_valid8, out_data8, out_ch8} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_out8 (pass %0d): got v=%b d=%h ch=%0d, want all 0",
                         k, out_valid8, out_data8, out_ch8);
            end
            n_tests++;
            if (in_ready8 !== 8'h00 || in_ready5 !== 5'h00) begin
                n_fail++;
                $display("FAIL reset_in_ready (pass %0d): got %h/%h, want 00/00",
                         k, in_ready8, in_ready5);
            end
            tick();
        end
        in_valid8 = '0;
        in_valid5 = '0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_explicit_sel();
        beat_t b;
        mode8      = MODE_SEL;
        sel8       = 3'd3;
        in_valid8  = 8'h08;
        out_ready8 = 1'b1;
        set_data(0);
        in_data8[3*8 +: 8] = 8'hA5;
        #1;
        n_tests++;
        if (in_ready8 !== 8'h08) begin
            n_fail++;
            $display("FAIL sel_in_ready: got %h want 08", in_ready8);
        end
        b.ch = 3'd3; b.data = 8'hA5; sb.push_back(b);
        tick();
        in_valid8 = 8'h00;
        #1;
        n_tests++;
        if (out_valid8 !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL sel_out_valid: got %b want 1", out_valid8);
        end else begin
            b = sb.pop_front();
            n_tests++;
            if ({out_ch8, out_data8} !== {b.ch, b.data}) begin
                n_fail++;
                $display("FAIL sel_beat: got ch=%0d d=%h want ch=%0d d=%h",
                         out_ch8, out_data8, b.ch, b.data);
            end
        end
        tick();
        n_tests++;
        if (out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_bubble: out_valid got %b want 0", out_valid8);
        end
    endtask

    task automatic test_stall();
        beat_t b;
        mode8      = MODE_SEL;
        sel8       = 3'd2;
        in_valid8  = 8'hFF;
        out_ready8 = 1'b1;
        set_data(0);
        #1;
        n_tests++;
        if (in_ready8 !== 8'h04) begin
            n_fail++;
            $display("FAIL stall_load_ready: got %h want 04", in_ready8);
        end
        sb.push_back(mk_beat(2, 0));
        tick();
        out_ready8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_data(c + 1);
            #1;
            n_tests++;
            if (in_ready8 !== 8'h00) begin
                n_fail++;
                $display("FAIL stall_in_ready cyc %0d: got %h want 00", c, in_ready8);
            end
            n_tests++;
            if (out_valid8 !== 1'b1 || out_data8 !== sb[0].data || out_ch8 !== sb[0].ch) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         c, out_valid8, out_ch8, out_data8, sb[0].ch, sb[0].data);
            end
            tick();
        end
        // Release: the pending beat drains and the slot refills in one cycle.
        out_ready8 = 1'b1;
        set_data(9);
        #1;
        n_tests++;
        if (in_ready8 !== 8'h04) begin
            n_fail++;
            $display("FAIL stall_refill_ready: got %h want 04", in_ready8);
        end
        b = sb.pop_front();
        n_tests++;
        if ({out_ch8, out_data8} !== {b.ch, b.data}) begin
            n_fail++;
            $display("FAIL stall_beat0: got ch=%0d d=%h want ch=%0d d=%h",
                     out_ch8, out_data8, b.ch, b.data);
        end
        sb.push_back(mk_beat(2, 9));
        tick();
        in_valid8 = 8'h00;
        #1;
        b = sb.pop_front();
        n_tests++;
        if (out_valid8 !== 1'b1 || {out_ch8, out_data8} !== {b.ch, b.data}) begin
            n_fail++;
            $display("FAIL stall_beat1: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     out_valid8, out_ch8, out_data8, b.ch, b.data);
        end
        tick();
        n_tests++;
        if (out_valid8 !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: out_valid got %b want 0, sb left %0d",
                     out_valid8, sb.size());
        end
    endtask

    // Shared cycle body for round-robin scenarios: checks the grant, consumes
    // the pending beat against the scoreboard and records the new one.
    task automatic test_round_robin(input logic [7:0] valid, input int n, input int seq_sel);
        beat_t b;
        int    exp_ch;
        int    sparse_seq[4] = '{4, 7, 1, 4};
        mode8      = MODE_RR;
        in_valid8  = valid;
        out_ready8 = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_ch = (seq_sel == 0) ? (k % 8) : sparse_seq[k % 4];
            set_data(k);
            #1;
            n_tests++;
            if (in_ready8 !== 8'(1 << exp_ch)) begin
                n_fail++;
                $display("FAIL rr%0d_grant cyc %0d: got %h want %h",
                         seq_sel, k, in_ready8, 8'(1 << exp_ch));
            end
            n_tests++;
            if (out_valid8 !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL rr%0d_valid cyc %0d: got %b want %b",
                         seq_sel, k, out_valid8, sb.size() != 0);
            end
            if (out_valid8 && sb.size() != 0) begin
                b = sb.pop_front();
                n_tests++;
                if ({out_ch8, out_data8} !== {b.ch, b.data}) begin
                    n_fail++;
                    $display("FAIL rr%0d_beat cyc %0d: got ch=%0d d=%h want ch=%0d d=%h",
                             seq_sel, k, out_ch8, out_data8, b.ch, b.data);
                end
            end
            sb.push_back(mk_beat(exp_ch, k));
            tick();
        end
        in_valid8 = 8'h00;
        #1;
        b = sb.pop_front();
        n_tests++;
        if (out_valid8 !== 1'b1 || {out_ch8, out_data8} !== {b.ch, b.data}) begin
            n_fail++;
            $display("FAIL rr%0d_last: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     seq_sel, out_valid8, out_ch8, out_data8, b.ch, b.data);
        end
        tick();
    endtask

    task automatic test_no_grant();
        beat_t b;
        mode5      = MODE_SEL;
        sel5       = 3'd2;
        in_valid5  = 5'h1F;
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'h50 + i);
        out_ready5 = 1'b1;
        #1;
        n_tests++;
        if (in_ready5 !== 5'b00100) begin
            n_fail++;
            $display("FAIL n5_load_ready: got %b want 00100", in_ready5);
        end
        b.ch = 3'd2; b.data = 8'h52; sb5.push_back(b);
        tick();
        sel5       = 3'd6;
        out_ready5 = 1'b0;
        #1;
        n_tests++;
        if (in_ready5 !== 5'b00000 || out_valid5 !== 1'b1) begin
            n_fail++;
            $display("FAIL n5_stall: got ready=%b v=%b want 00000/1", in_ready5, out_valid5);
        end
        tick();
        out_ready5 = 1'b1;
        #1;
        n_tests++;
        if (in_ready5 !== 5'b00000) begin
            n_fail++;
            $display("FAIL n5_oob_ready: got %b want 00000", in_ready5);
        end
        b = sb5.pop_front();
        n_tests++;
        if (out_valid5 !== 1'b1 || {out_ch5, out_data5} !== {b.ch, b.data}) begin
            n_fail++;
            $display("FAIL n5_beat: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     out_valid5, out_ch5, out_data5, b.ch, b.data);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (out_valid5 !== 1'b0 || in_ready5 !== 5'b00000) begin
                n_fail++;
                $display("FAIL n5_idle cyc %0d: got v=%b ready=%b want 0/00000",
                         k, out_valid5, in_ready5);
            end
        end
        in_valid5 = '0;
    endtask

    task automatic test_async_reset();
        beat_t b;
        mode8      = MODE_SEL;
        sel8       = 3'd5;
        in_valid8  = 8'h20;
        out_ready8 = 1'b1;
        set_data(12);
        #1;
        n_tests++;
        if (in_ready8 !== 8'h20) begin
            n_fail++;
            $display("FAIL ar_load_ready: got %h want 20", in_ready8);
        end
        sb.push_back(mk_beat(5, 12));
        tick();
        in_valid8  = 8'h00;
        out_ready8 = 1'b0;
        #1;
        n_tests++;
        if (out_valid8 !== 1'b1 || out_ch8 !== 3'd5 || out_data8 !== sb[0].data) begin
            n_fail++;
            $display("FAIL ar_pending: got v=%b ch=%0d d=%h want v=1 ch=5 d=%h",
                     out_valid8, out_ch8, out_data8, sb[0].data);
        end
        // Assert reset mid-cycle; outputs must clear before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid8, out_data8, out_ch8} !== 12'h000) begin
            n_fail++;
            $display("FAIL ar_async_clear: got v=%b d=%h ch=%0d want all 0",
                     out_valid8, out_data8, out_ch8);
        end
        sb.delete();
        rst_n = 1'b1;
        tick();
        mode8      = MODE_RR;
        in_valid8  = 8'hFF;
        out_ready8 = 1'b1;
        set_data(3);
        #1;
        n_tests++;
        if (in_ready8 !== 8'h01) begin
            n_fail++;
            $display("FAIL ar_first_grant: got %h want 01", in_ready8);
        end
        sb.push_back(mk_beat(0, 3));
        tick();
        in_valid8 = 8'h00;
        #1;
        b = sb.pop_front();
        n_tests++;
        if (out_valid8 !== 1'b1 || {out_ch8, out_data8} !== {b.ch, b.data}) begin
            n_fail++;
            $display("FAIL ar_first_beat: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     out_valid8, out_ch8, out_data8, b.ch, b.data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_explicit_sel();
        test_stall();
        test_round_robin(8'hFF, 10, 0);
        test_round_robin(8'b1001_0010, 4, 1);
        test_no_grant();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
